// File: rtl/clock_pkg.sv
// Shared clock definitions: field widths, field limits and edit FSM encoding.
package clock_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
    localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

    // Edit FSM encoding
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StEditH = 2'd1;
    localparam logic [1:0] StEditM = 2'd2;
    localparam logic [1:0] StEditS = 2'd3;

    // Blink mask {hour,min,sec}: only the field being edited follows the phase.
    function automatic logic [2:0] field_mask(input logic [1:0] st, input logic phase);
        logic [2:0] m;
        m = 3'b000;
        unique case (st)
            StEditH: m = {phase, 2'b00};
            StEditM: m = {1'b0, phase, 1'b0};
            StEditS: m = {2'b00, phase};
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/clock_time_setter_if.sv
// Panel/counter side signals of the time setter.
interface clock_time_setter_if;
    import clock_pkg::*;

    logic                btn_mode;
    logic                btn_inc;
    logic [HOUR_W-1:0]   cur_hour;
    logic [MIN_W-1:0]    cur_min;
    logic [SEC_W-1:0]    cur_sec;
    logic [HOUR_W-1:0]   set_hour;
    logic [MIN_W-1:0]    set_min;
    logic [SEC_W-1:0]    set_sec;
    logic                load;
    logic                editing;
    logic [2:0]          blink_mask;

    modport master (
        output btn_mode, btn_inc, cur_hour, cur_min, cur_sec,
        input  set_hour, set_min, set_sec, load, editing, blink_mask
    );

    modport slave (
        input  btn_mode, btn_inc, cur_hour, cur_min, cur_sec,
        output set_hour, set_min, set_sec, load, editing, blink_mask
    );

endinterface

// File: rtl/button_debouncer.sv
// Synchronises and debounces one active-low push-button; one pulse per press.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pressed_level,
    output logic press_pulse
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            pulse_q;
    logic            sample_pressed;

    assign sample_pressed = ~sync_q[1];

    // Two-flop synchroniser, reset to the released level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], btn_n};
    end

    // Count consecutive samples that disagree with the level; a matching sample restarts.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sample_pressed != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) level_d = sample_pressed;
            else                                     cnt_d   = cnt_q + 1'b1;
        end
    end

    // Debounced level and released->pressed pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= level_d & ~level_q;
        end
    end

    assign pressed_level = level_q;
    assign press_pulse   = pulse_q;

endmodule

// File: rtl/clock_time_setter.sv
// Front-panel time entry: walks hour/minute/second edit fields and commits with a load strobe.
module clock_time_setter import clock_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES   = 500_000,
    parameter int unsigned TIMEOUT_CYCLES    = 1_500_000_000,
    parameter int unsigned BLINK_HALF_CYCLES = 12_500_000
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_time_setter_if.slave   bus
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned BlkW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

    logic mode_ev, inc_ev, mode_lvl, inc_lvl, any_ev, timeout;
    logic unused_levels;

    logic [1:0]        state_q, state_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic              load_q, load_d;
    logic              editing_q, editing_d;
    logic [2:0]        mask_q, mask_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [BlkW-1:0]   blk_q, blk_d;
    logic              phase_q, phase_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk           (clk),
        .reset         (reset),
        .btn_n         (bus.btn_mode),
        .pressed_level (mode_lvl),
        .press_pulse   (mode_ev)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk           (clk),
        .reset         (reset),
        .btn_n         (bus.btn_inc),
        .pressed_level (inc_lvl),
        .press_pulse   (inc_ev)
    );

    assign unused_levels = mode_lvl ^ inc_lvl;
    assign any_ev        = mode_ev | inc_ev;
    assign timeout       = (state_q != StIdle) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    // Edit FSM and shadow fields; mode outranks inc, timeout abandons without load.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        load_d  = 1'b0;
        if (timeout) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mode_ev) begin
                        state_d = StEditH;
                        hour_d  = bus.cur_hour;
                        min_d   = bus.cur_min;
                        sec_d   = bus.cur_sec;
                    end
                end
                StEditH: begin
                    if (mode_ev)     state_d = StEditM;
                    else if (inc_ev) hour_d  = (hour_q == MAX_HOUR) ? '0 : hour_q + 1'b1;
                end
                StEditM: begin
                    if (mode_ev)     state_d = StEditS;
                    else if (inc_ev) min_d   = (min_q == MAX_MIN) ? '0 : min_q + 1'b1;
                end
                default: begin
                    if (mode_ev) begin
                        state_d = StIdle;
                        load_d  = 1'b1;
                    end else if (inc_ev) begin
                        sec_d = (sec_q == MAX_SEC) ? '0 : sec_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Idle timer and blink phase; both restart on any press so the edit shows at once.
    always_comb begin
        tmo_d = (state_q == StIdle || any_ev) ? '0 : tmo_q + 1'b1;
        blk_d   = blk_q + 1'b1;
        phase_d = phase_q;
        if (any_ev) begin
            blk_d   = '0;
            phase_d = 1'b0;
        end else if (blk_q == BlkW'(BLINK_HALF_CYCLES - 1)) begin
            blk_d   = '0;
            phase_d = ~phase_q;
        end
        editing_d = (state_d != StIdle);
        mask_d    = field_mask(state_d, phase_d);
    end

    // State, shadow and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            hour_q    <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            load_q    <= 1'b0;
            editing_q <= 1'b0;
            mask_q    <= 3'b000;
            tmo_q     <= '0;
            blk_q     <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            load_q    <= load_d;
            editing_q <= editing_d;
            mask_q    <= mask_d;
            tmo_q     <= tmo_d;
            blk_q     <= blk_d;
            phase_q   <= phase_d;
        end
    end

    assign bus.set_hour   = hour_q;
    assign bus.set_min    = min_q;
    assign bus.set_sec    = sec_q;
    assign bus.load       = load_q;
    assign bus.editing    = editing_q;
    assign bus.blink_mask = mask_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Self-checking bench for clock_time_setter with a press-level reference model.
module tb_clock_time_setter;
    import clock_pkg::*;

    localparam int unsigned DEB = 8;
    localparam int unsigned TMO = 200;
    localparam int unsigned BLK = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    clock_time_setter_if bus ();

    clock_time_setter #(
        .DEBOUNCE_CYCLES   (DEB),
        .TIMEOUT_CYCLES    (TMO),
        .BLINK_HALF_CYCLES (BLK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Load monitor: counts strobes and captures what the counter would receive.
    int unsigned load_cnt = 0;
    int unsigned ld_h, ld_m, ld_s;
    logic        ld_ed, ld_ed_prev;
    logic        ed_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.load === 1'b1) begin
            load_cnt++;
            ld_h       = bus.set_hour;
            ld_m       = bus.set_min;
            ld_s       = bus.set_sec;
            ld_ed      = bus.editing;
            ld_ed_prev = ed_prev;
        end
        ed_prev = bus.editing;
    end

    // Reference model: 0 = idle, 1/2/3 = editing hour/min/sec.
    int          m_fld = 0;
    int          m_h = 0, m_m = 0, m_s = 0;
    int unsigned exp_loads = 0;

    function automatic int unsigned exp_mask();
        case (m_fld)
            1:       return 4;
            2:       return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_event(input bit mode, input bit inc);
        if (mode) begin
            if (m_fld == 0) begin
                m_fld = 1;
                m_h = int'(bus.cur_hour);
                m_m = int'(bus.cur_min);
                m_s = int'(bus.cur_sec);
            end else if (m_fld == 3) begin
                m_fld = 0;
                exp_loads++;
            end else begin
                m_fld++;
            end
        end else if (inc) begin
            case (m_fld)
                1: m_h = (m_h + 1) % 24;
                2: m_m = (m_m + 1) % 60;
                3: m_s = (m_s + 1) % 60;
                default: ;
            endcase
        end
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus.cur_hour = 5'(h);
        bus.cur_min  = 6'(m);
        bus.cur_sec  = 6'(s);
    endtask

    // One clean press: 14 cycles held, 20 released; checks at both points.
    task automatic press(input bit mode, input bit inc, input string tag);
        int unsigned loads_before;
        loads_before = exp_loads;
        bus.btn_mode = ~mode;
        bus.btn_inc  = ~inc;
        repeat (14) @(negedge clk);
        model_event(mode, inc);
        check_eq({tag, ".editing"}, bus.editing, (m_fld != 0) ? 1 : 0);
        check_eq({tag, ".mask_shown"}, bus.blink_mask, 0);
        if (m_fld != 0) begin
            check_eq({tag, ".hour"}, bus.set_hour, m_h);
            check_eq({tag, ".min"}, bus.set_min, m_m);
            check_eq({tag, ".sec"}, bus.set_sec, m_s);
        end
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        repeat (20) @(negedge clk);
        check_eq({tag, ".mask_blank"}, bus.blink_mask, exp_mask());
        check_eq({tag, ".loads"}, load_cnt, exp_loads);
        if (exp_loads != loads_before) begin
            check_eq({tag, ".ld_hour"}, ld_h, m_h);
            check_eq({tag, ".ld_min"}, ld_m, m_m);
            check_eq({tag, ".ld_sec"}, ld_s, m_s);
            check_eq({tag, ".ld_edit_fall"}, {ld_ed_prev, ld_ed}, 2);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".load"}, bus.load, 0);
        check_eq({tag, ".editing"}, bus.editing, 0);
        check_eq({tag, ".mask"}, bus.blink_mask, 0);
        check_eq({tag, ".set"}, {bus.set_hour, bus.set_min, bus.set_sec}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int unsigned loads_mark;
        bit r_mode, r_inc;

        // 1: reset with mode held, one event after release
        reset        = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b1;
        set_cur(0, 0, 0);
        repeat (3) @(negedge clk);
        check_quiet("t1.in_reset");
        reset = 1'b1;
        lat   = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.editing === 1'b1) begin
                lat = i;
                break;
            end
        end
        check_eq("t1.latency", lat, 11);
        model_event(1'b1, 1'b0);
        repeat (40) @(negedge clk);
        check_eq("t1.held_editing", bus.editing, 1);
        check_eq("t1.held_mask_other", bus.blink_mask & 3'b011, 0);
        bus.btn_mode = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t1.no_load", load_cnt, 0);
        press(1'b1, 1'b0, "t1.m1");
        press(1'b1, 1'b0, "t1.m2");
        press(1'b1, 1'b0, "t1.m3");

        // 2: bouncing inc yields a single increment
        set_cur(5, 0, 0);
        press(1'b1, 1'b0, "t2.enter");
        for (int i = 0; i < 20; i++) begin
            bus.btn_inc = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) @(negedge clk);
        end
        bus.btn_inc = 1'b0;
        repeat (20) @(negedge clk);
        model_event(1'b0, 1'b1);
        check_eq("t2.hour_held", bus.set_hour, 6);
        bus.btn_inc = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t2.hour_released", bus.set_hour, 6);
        press(1'b1, 1'b0, "t2.m1");
        press(1'b1, 1'b0, "t2.m2");
        press(1'b1, 1'b0, "t2.m3");

        // 3: 12:34:56 -> 14:35:56
        set_cur(12, 34, 56);
        press(1'b1, 1'b0, "t3.p1");
        press(1'b0, 1'b1, "t3.p2");
        press(1'b0, 1'b1, "t3.p3");
        press(1'b1, 1'b0, "t3.p4");
        press(1'b0, 1'b1, "t3.p5");
        press(1'b1, 1'b0, "t3.p6");
        press(1'b1, 1'b0, "t3.p7");
        check_eq("t3.load_value", {ld_h[7:0], ld_m[7:0], ld_s[7:0]}, {8'd14, 8'd35, 8'd56});

        // 4: every field wraps
        set_cur(23, 59, 59);
        press(1'b1, 1'b0, "t4.p1");
        press(1'b0, 1'b1, "t4.p2");
        press(1'b1, 1'b0, "t4.p3");
        press(1'b0, 1'b1, "t4.p4");
        press(1'b1, 1'b0, "t4.p5");
        press(1'b0, 1'b1, "t4.p6");
        press(1'b1, 1'b0, "t4.p7");
        check_eq("t4.load_value", ld_h + ld_m + ld_s, 0);

        // 5: timeout abandons the edit
        set_cur(7, 8, 9);
        press(1'b1, 1'b0, "t5.enter");
        repeat (TMO) @(negedge clk);
        m_fld = 0;
        check_eq("t5.editing", bus.editing, 0);
        check_eq("t5.mask", bus.blink_mask, 0);
        check_eq("t5.loads", load_cnt, exp_loads);

        // 6: simultaneous mode+inc, then reset mid-edit
        set_cur(3, 10, 20);
        press(1'b1, 1'b0, "t6.enter");
        press(1'b1, 1'b0, "t6.to_min");
        press(1'b1, 1'b1, "t6.both");
        check_eq("t6.min_kept", bus.set_min, 10);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_fld = 0;
        m_h   = 0;
        m_m   = 0;
        m_s   = 0;
        repeat (3) @(negedge clk);
        check_quiet("t6.after_reset");
        check_eq("t6.loads", load_cnt, exp_loads);

        // Random press sequences against the model
        for (int i = 0; i < 60; i++) begin
            set_cur($urandom_range(23), $urandom_range(59), $urandom_range(59));
            r_mode = ($urandom_range(2) == 0);
            r_inc  = !r_mode || ($urandom_range(4) == 0);
            press(r_mode, r_inc, $sformatf("rnd%0d", i));
        end
        loads_mark = 0;
        while (m_fld != 0 && loads_mark < 4) begin
            press(1'b1, 1'b0, "rnd.close");
            loads_mark++;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
